vel_rotator: RTL and testbench

// - Converts the robot's body-frame velocity (vx_b, vy_b, wz) into global-frame velocity (vx, vy, wz).
// - Rotates the body frame by the current heading theta, using an iterative CORDIC to get sin/cos.
// - Sits directly upstream of the position calculator: it drives that block's VX/VY/WZ inputs.
// - Its theta input is the position calculator's THETA output (degrees), closing the odometry loop.

---
 rtl/vel_rot_pkg.sv | 43 ++++
 rtl/cordic_rotator.sv | 63 ++++++
 rtl/vel_rotator.sv | 177 +++++++++++++++++
 tb/tb_vel_rotator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vel_rot_pkg.sv
// Shared FSM encoding, Q15 angle constants and the CORDIC arctangent table
// for the body-to-global velocity rotator.
package vel_rot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrap,
        StFold,
        StCordic,
        StMult,
        StOut
    } state_e;

    // Angles are Q15 degrees; DEG2RAD and CORDIC_GAIN are Q15 scalars.
    localparam int signed DEG_90      = 32'sh002D_0000;
    localparam int signed DEG_180     = 32'sh005A_0000;
    localparam int signed DEG_360     = 32'sh00B4_0000;
    localparam int signed DEG2RAD     = 572;
    localparam int signed CORDIC_GAIN = 19898;

    function automatic int signed atan_q15(input int unsigned idx);
        case (idx)
            0:       return 25736;
            1:       return 15193;
            2:       return 8027;
            3:       return 4075;
            4:       return 2045;
            5:       return 1024;
            6:       return 512;
            7:       return 256;
            8:       return 128;
            9:       return 64;
            10:      return 32;
            11:      return 16;
            12:      return 8;
            13:      return 4;
            14:      return 2;
            15:      return 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: load x/y/z, then one micro-rotation per step
// at the index supplied by the controller.
module cordic_rotator
    import vel_rot_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned IdxW  = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic                    step_i,
    input  logic [IdxW-1:0]         idx_i,
    input  logic signed [Width-1:0] x_i,
    input  logic signed [Width-1:0] y_i,
    input  logic signed [Width-1:0] z_i,
    output logic signed [Width-1:0] x_o,
    output logic signed [Width-1:0] y_o
);

    logic signed [Width-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [Width-1:0] x_sh, y_sh, atan;

    always_comb begin
        x_sh = x_q >>> idx_i;
        y_sh = y_q >>> idx_i;
        atan = Width'(atan_q15(int'(idx_i)));
        x_d  = x_q;
        y_d  = y_q;
        z_d  = z_q;
        if (load_i) begin
            x_d = x_i;
            y_d = y_i;
            z_d = z_i;
        end else if (step_i) begin
            if (!z_q[Width-1]) begin
                x_d = x_q - y_sh;
                y_d = y_q + x_sh;
                z_d = z_q - atan;
            end else begin
                x_d = x_q + y_sh;
                y_d = y_q - x_sh;
                z_d = z_q + atan;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/vel_rotator.sv
// Body-to-global velocity rotation: wraps and folds the heading, runs the CORDIC
// for sin/cos, then rotates (vxb, vyb) with saturating fixed-point multiplies.
module vel_rotator
    import vel_rot_pkg::*;
#(
    parameter int unsigned DATAWIDTH_N  = 32,
    parameter int unsigned FRACTIONAL_Q = 15,
    parameter int unsigned CORDIC_ITER  = 16
) (
    input  logic                          VEL_ROTATOR_CLOCK_50,
    input  logic                          VEL_ROTATOR_Reset_InHigh,
    input  logic                          VEL_ROTATOR_START_InHigh,
    input  logic signed [DATAWIDTH_N-1:0] VEL_ROTATOR_VXB_InBus,
    input  logic signed [DATAWIDTH_N-1:0] VEL_ROTATOR_VYB_InBus,
    input  logic signed [DATAWIDTH_N-1:0] VEL_ROTATOR_WZB_InBus,
    input  logic signed [DATAWIDTH_N-1:0] VEL_ROTATOR_THETA_InBus,
    output logic signed [DATAWIDTH_N-1:0] VEL_ROTATOR_VX_OutBus,
    output logic signed [DATAWIDTH_N-1:0] VEL_ROTATOR_VY_OutBus,
    output logic signed [DATAWIDTH_N-1:0] VEL_ROTATOR_WZ_OutBus,
    output logic                          VEL_ROTATOR_BUSY_OutHigh,
    output logic                          VEL_ROTATOR_DONE_OutHigh
);

    localparam int unsigned N    = DATAWIDTH_N;
    localparam int unsigned W2   = 2 * N;
    localparam int unsigned IdxW = 5;

    localparam logic signed [N-1:0]  Deg90   = N'(DEG_90);
    localparam logic signed [N-1:0]  Deg180  = N'(DEG_180);
    localparam logic signed [N-1:0]  Deg360  = N'(DEG_360);
    localparam logic signed [N-1:0]  Gain    = N'(CORDIC_GAIN);
    localparam logic signed [W2-1:0] Deg2Rad = W2'(DEG2RAD);
    localparam logic signed [W2:0]   SatHi   = {{(N+2){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [W2:0]   SatLo   = {{(N+2){1'b1}}, {(N-1){1'b0}}};

    state_e state_q, state_d;
    logic signed [N-1:0] vxb_q, vxb_d, vyb_q, vyb_d, wzb_q, wzb_d, theta_q, theta_d;
    logic signed [N-1:0] vx_q, vx_d, vy_q, vy_d, wz_q, wz_d;
    logic                neg_q, neg_d;
    logic [IdxW-1:0]     iter_q, iter_d;

    logic                cordic_load, cordic_step, fold_neg;
    logic signed [N-1:0] theta_f, z_load, cx, sy, cos_v, sin_v;
    logic signed [W2-1:0] z_prod, p_xc, p_ys, p_xs, p_yc;

    function automatic logic signed [N-1:0] sat_shift(input logic signed [W2:0] sum);
        logic signed [W2:0] s;
        s = sum >>> FRACTIONAL_Q;
        if (s > SatHi) return {1'b0, {(N-1){1'b1}}};
        if (s < SatLo) return {1'b1, {(N-1){1'b0}}};
        return N'(s);
    endfunction

    // Fold into [-90, 90] deg so the CORDIC stays inside its convergence range.
    always_comb begin
        theta_f  = theta_q;
        fold_neg = 1'b0;
        if (theta_q > Deg90) begin
            theta_f  = theta_q - Deg180;
            fold_neg = 1'b1;
        end else if (theta_q < -Deg90) begin
            theta_f  = theta_q + Deg180;
            fold_neg = 1'b1;
        end
        z_prod = W2'(theta_f) * Deg2Rad;
        z_load = N'(z_prod >>> FRACTIONAL_Q);
        cos_v  = neg_q ? -cx : cx;
        sin_v  = neg_q ? -sy : sy;
        p_xc   = W2'(vxb_q) * W2'(cos_v);
        p_ys   = W2'(vyb_q) * W2'(sin_v);
        p_xs   = W2'(vxb_q) * W2'(sin_v);
        p_yc   = W2'(vyb_q) * W2'(cos_v);
    end

    always_comb begin
        state_d     = state_q;
        vxb_d       = vxb_q;
        vyb_d       = vyb_q;
        wzb_d       = wzb_q;
        theta_d     = theta_q;
        neg_d       = neg_q;
        iter_d      = iter_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        wz_d        = wz_q;
        cordic_load = 1'b0;
        cordic_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (VEL_ROTATOR_START_InHigh) begin
                    vxb_d   = VEL_ROTATOR_VXB_InBus;
                    vyb_d   = VEL_ROTATOR_VYB_InBus;
                    wzb_d   = VEL_ROTATOR_WZB_InBus;
                    theta_d = VEL_ROTATOR_THETA_InBus;
                    state_d = StWrap;
                end
            end
            StWrap: begin
                if (theta_q >= Deg180) begin
                    theta_d = theta_q - Deg360;
                end else if (theta_q < -Deg180) begin
                    theta_d = theta_q + Deg360;
                end else begin
                    state_d = StFold;
                end
            end
            StFold: begin
                neg_d       = fold_neg;
                iter_d      = '0;
                cordic_load = 1'b1;
                state_d     = StCordic;
            end
            StCordic: begin
                cordic_step = 1'b1;
                iter_d      = iter_q + IdxW'(1);
                if (iter_q == IdxW'(CORDIC_ITER - 1)) state_d = StMult;
            end
            StMult: begin
                vx_d    = sat_shift((W2+1)'(p_xc) - (W2+1)'(p_ys));
                vy_d    = sat_shift((W2+1)'(p_xs) + (W2+1)'(p_yc));
                wz_d    = wzb_q;
                state_d = StOut;
            end
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge VEL_ROTATOR_CLOCK_50 or posedge VEL_ROTATOR_Reset_InHigh) begin
        if (VEL_ROTATOR_Reset_InHigh) begin
            state_q <= StIdle;
            vxb_q   <= '0;
            vyb_q   <= '0;
            wzb_q   <= '0;
            theta_q <= '0;
            neg_q   <= 1'b0;
            iter_q  <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            wz_q    <= '0;
        end else begin
            state_q <= state_d;
            vxb_q   <= vxb_d;
            vyb_q   <= vyb_d;
            wzb_q   <= wzb_d;
            theta_q <= theta_d;
            neg_q   <= neg_d;
            iter_q  <= iter_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            wz_q    <= wz_d;
        end
    end

    cordic_rotator #(
        .Width(N),
        .IdxW (IdxW)
    ) u_cordic (
        .clk_i (VEL_ROTATOR_CLOCK_50),
        .rst_i (VEL_ROTATOR_Reset_InHigh),
        .load_i(cordic_load),
        .step_i(cordic_step),
        .idx_i (iter_q),
        .x_i   (Gain),
        .y_i   ('0),
        .z_i   (z_load),
        .x_o   (cx),
        .y_o   (sy)
    );

    assign VEL_ROTATOR_VX_OutBus    = vx_q;
    assign VEL_ROTATOR_VY_OutBus    = vy_q;
    assign VEL_ROTATOR_WZ_OutBus    = wz_q;
    assign VEL_ROTATOR_BUSY_OutHigh = (state_q != StIdle);
    assign VEL_ROTATOR_DONE_OutHigh = (state_q == StOut);

endmodule

// File: tb/tb_vel_rotator.sv
// Self-checking bench for vel_rotator: table of vectors with a real-valued rotation
// model, a scoreboard queue popped on DONE, plus reset/ignored-START sequences.
module tb_vel_rotator;

    logic clk = 1'b0;
    logic rst, start, busy, done;
    logic signed [31:0] vxb, vyb, wzb, theta, vx, vy, wz;

    typedef struct {
        logic signed [31:0] theta, vxb, vyb, wzb, exp_vx, exp_vy;
        longint             tolx, toly;
        int                 lat;
    } vec_t;

    typedef struct {
        logic signed [31:0] vx, vy, wz;
        longint             tolx, toly;
        int                 lat, t0, id;
    } exp_t;

    int     n_vec  = 0;
    int     n_miss = 0;
    int     n_done = 0;
    int     cyc    = 0;
    exp_t   sb[$];

    vel_rotator dut (
        .VEL_ROTATOR_CLOCK_50    (clk),
        .VEL_ROTATOR_Reset_InHigh(rst),
        .VEL_ROTATOR_START_InHigh(start),
        .VEL_ROTATOR_VXB_InBus   (vxb),
        .VEL_ROTATOR_VYB_InBus   (vyb),
        .VEL_ROTATOR_WZB_InBus   (wzb),
        .VEL_ROTATOR_THETA_InBus (theta),
        .VEL_ROTATOR_VX_OutBus   (vx),
        .VEL_ROTATOR_VY_OutBus   (vy),
        .VEL_ROTATOR_WZ_OutBus   (wz),
        .VEL_ROTATOR_BUSY_OutHigh(busy),
        .VEL_ROTATOR_DONE_OutHigh(done)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input longint act, input longint exp,
                       input longint tol);
        longint d;
        n_vec++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_miss++;
            $display("FAIL %s[%0d]: got %0d, want %0d +/- %0d", name, id, act, exp, tol);
        end
    endtask

    // Expected values use the angle as quantised by DEG2RAD, after wrap and fold.
    function automatic vec_t model(input longint deg, input longint ivx, input longint ivy,
                                   input longint iwz);
        vec_t   v;
        longint th, z, ax, ay;
        int     k;
        bit     neg;
        real    a, c, s, ex, ey;
        th = deg * 32768;
        v.theta = 32'(th);
        k = 0;
        while (th >= 180 * 32768) begin th -= 360 * 32768; k++; end
        while (th < -180 * 32768) begin th += 360 * 32768; k++; end
        neg = 1'b0;
        if (th > 90 * 32768) begin th -= 180 * 32768; neg = 1'b1; end
        else if (th < -90 * 32768) begin th += 180 * 32768; neg = 1'b1; end
        z = (th * 572) >>> 15;
        a = real'(z) / 32768.0;
        c = $cos(a);
        s = $sin(a);
        if (neg) begin c = -c; s = -s; end
        ex = real'(ivx) * c - real'(ivy) * s;
        ey = real'(ivx) * s + real'(ivy) * c;
        v.vxb = 32'(ivx);
        v.vyb = 32'(ivy);
        v.wzb = 32'(iwz);
        ax = (ivx < 0) ? -ivx : ivx;
        ay = (ivy < 0) ? -ivy : ivy;
        v.tolx = (4 * (ax + ay)) / 32768 + 2;
        v.toly = v.tolx;
        if (ex > 2147483647.0) begin v.exp_vx = 32'sh7FFF_FFFF; v.tolx = 0; end
        else if (ex < -2147483648.0) begin v.exp_vx = 32'sh8000_0000; v.tolx = 0; end
        else v.exp_vx = 32'($rtoi(ex + ((ex >= 0.0) ? 0.5 : -0.5)));
        if (ey > 2147483647.0) begin v.exp_vy = 32'sh7FFF_FFFF; v.toly = 0; end
        else if (ey < -2147483648.0) begin v.exp_vy = 32'sh8000_0000; v.toly = 0; end
        else v.exp_vy = 32'($rtoi(ey + ((ey >= 0.0) ? 0.5 : -0.5)));
        v.lat = 20 + k;
        return v;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_done: got DONE at cycle %0d, want none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("vx", e.id, longint'(vx), longint'(e.vx), e.tolx);
                    chk("vy", e.id, longint'(vy), longint'(e.vy), e.toly);
                    chk("wz", e.id, longint'(wz), longint'(e.wz), 0);
                    chk("latency", e.id, longint'(cyc - e.t0 + 1), longint'(e.lat), 0);
                end
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin @(posedge clk); #1; n++; end
        if (busy) begin
            n_vec++;
            n_miss++;
            $display("FAIL idle_timeout: got busy=1 after %0d cycles, want 0", budget);
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        exp_t e;
        wait_idle(400);
        theta = v.theta;
        vxb   = v.vxb;
        vyb   = v.vyb;
        wzb   = v.wzb;
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        e.vx   = v.exp_vx;
        e.vy   = v.exp_vy;
        e.wz   = v.wzb;
        e.tolx = v.tolx;
        e.toly = v.toly;
        e.lat  = v.lat;
        e.t0   = cyc;
        e.id   = id;
        sb.push_back(e);
        theta = $urandom;
        vxb   = $urandom;
        vyb   = $urandom;
        wzb   = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 600) begin @(posedge clk); #1; n++; end
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: got %0d outstanding, want 0", sb.size());
        end
    endtask

    initial begin
        vec_t tbl[$];
        int   d0, n;

        rst   = 1'b1;
        start = 1'b0;
        theta = '0;
        vxb   = '0;
        vyb   = '0;
        wzb   = '0;
        fork
            monitor();
        join_none

        tbl.push_back(model(0,     32'h8000, 32'h4000, 32'h2000));
        tbl.push_back(model(90,    32'h8000, 0,        32'h1234));
        tbl.push_back(model(450,   32'h8000, 0,        -32'h1234));
        tbl.push_back(model(-135,  32'h8000, 0,        0));
        tbl.push_back(model(45,    64'sh7FFF_FFFF, 64'sh7FFF_FFFF, 1));
        tbl.push_back(model(45,    -64'sh8000_0000, -64'sh8000_0000, -1));
        tbl.push_back(model(30,    32'h8000, 32'h4000, -32'h1000));
        tbl.push_back(model(-170,  32'h6000, -32'h2000, 32'h100));
        tbl.push_back(model(180,   32'h8000, 32'h2000, 5));
        tbl.push_back(model(-180,  32'h8000, 0,        7));
        tbl.push_back(model(-900,  32'h4000, 32'h4000, 0));
        tbl.push_back(model(3660,  32'h8000, 0,        9));
        tbl.push_back(model(91,    32'h8000, 32'h8000, 3));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_vx",   0, longint'(vx), 0, 0);
        chk("rst_vy",   0, longint'(vy), 0, 0);
        chk("rst_wz",   0, longint'(wz), 0, 0);
        chk("rst_busy", 0, longint'(busy), 0, 0);
        chk("rst_done", 0, longint'(done), 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) apply(tbl[i], i);
        drain();

        // START pulses while busy and during the DONE cycle must all be ignored.
        d0 = n_done;
        apply(tbl[0], 100);
        for (int i = 1; i <= 3; i++) begin
            theta = 32'sh0010_0000 * i;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 60) begin @(negedge clk); n++; end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL done_timeout: got no DONE in %0d cycles, want one", n);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("one_done_per_start", 100, longint'(n_done - d0), 1, 0);
        chk("idle_after_op",      100, longint'(busy), 0, 0);
        chk("hold_vx",            100, longint'(vx), longint'(tbl[0].exp_vx), tbl[0].tolx);
        chk("hold_vy",            100, longint'(vy), longint'(tbl[0].exp_vy), tbl[0].toly);

        // Asynchronous reset in the middle of the CORDIC phase aborts the op.
        apply(tbl[1], 101);
        repeat (8) @(posedge clk);
        #3 rst = 1'b1;
        #2;
        chk("abort_vx",   101, longint'(vx), 0, 0);
        chk("abort_vy",   101, longint'(vy), 0, 0);
        chk("abort_wz",   101, longint'(wz), 0, 0);
        chk("abort_busy", 101, longint'(busy), 0, 0);
        chk("abort_done", 101, longint'(done), 0, 0);
        sb.delete();
        d0 = n_done;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("no_done_after_abort", 101, longint'(n_done - d0), 0, 0);

        apply(tbl[3], 102);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
